// File: rtl/roce_stack_addr_translator.sv
// Direct-mapped VA->PA translation for the RoCE DMA path (one per rd/wr side).
// Hit/miss counters are built only when ROCE_ADDR_XLAT_STATS_EN is defined.
module roce_stack_addr_translator #(
  parameter int NUM_ENTRIES = 64,
  parameter int PAGE_BITS   = 21
) (
  input  logic                   clk_i,
  input  logic                   aresetn_i,
  input  logic                   req_addr_valid_i,
  output logic                   req_addr_ready_o,
  input  logic [63:0]            req_addr_vaddr_i,
  output logic                   resp_addr_valid_o,
  input  logic                   resp_addr_ready_i,
  output logic [63:0]            resp_addr_paddr_o,
  output logic                   resp_addr_miss_o,
  input  logic                   cfg_wr_valid_i,
  output logic                   cfg_wr_ready_o,
  input  logic [63-PAGE_BITS:0]  cfg_wr_vpn_i,
  input  logic [63-PAGE_BITS:0]  cfg_wr_ppn_i,
  input  logic                   cfg_wr_en_entry_i,
  input  logic                   flush_i,
  output logic [31:0]            stat_hit_cnt_o,
  output logic [31:0]            stat_miss_cnt_o
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int VPN_W = 64 - PAGE_BITS;
  localparam int TAG_W = VPN_W - IDX_W;
  localparam int ENT_W = TAG_W + VPN_W;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [ENT_W-1:0]       mem [NUM_ENTRIES];
  logic [ENT_W-1:0]       rd_q;
  logic [NUM_ENTRIES-1:0] vld_q, vld_d;
  logic [63:0]            vaddr_q;
  logic [63:0]            paddr_q, paddr_d;
  logic                   miss_q, miss_d;

  logic                   req_rdy, cfg_rdy, rsp_vld;
  logic                   req_hs, wr_hs, resp_hs;
  logic [IDX_W-1:0]       req_idx, wr_idx, lk_idx;
  logic [VPN_W-1:0]       lk_vpn, rd_ppn;
  logic [TAG_W-1:0]       lk_tag, rd_tag;
  logic                   hit;

  assign req_hs  = req_addr_valid_i & req_rdy;
  assign wr_hs   = cfg_wr_valid_i & cfg_rdy;
  assign resp_hs = rsp_vld & resp_addr_ready_i;

  assign req_idx = req_addr_vaddr_i[PAGE_BITS +: IDX_W];
  assign wr_idx  = cfg_wr_vpn_i[IDX_W-1:0];

  assign lk_vpn  = vaddr_q[63:PAGE_BITS];
  assign lk_idx  = lk_vpn[IDX_W-1:0];
  assign lk_tag  = lk_vpn[VPN_W-1:IDX_W];
  assign rd_tag  = rd_q[ENT_W-1:VPN_W];
  assign rd_ppn  = rd_q[VPN_W-1:0];

  // A flush in the lookup cycle must already turn this lookup into a miss
  assign hit = vld_q[lk_idx] & (rd_tag == lk_tag) & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (wr_hs) begin
      mem[wr_idx] <= {cfg_wr_vpn_i[VPN_W-1:IDX_W], cfg_wr_ppn_i};
    end
    if (req_hs) begin
      rd_q <= mem[req_idx];
    end
  end

  always_comb begin
    vld_d = vld_q;
    if (flush_i) begin
      vld_d = '0;
    end
    if (wr_hs) begin
      vld_d[wr_idx] = cfg_wr_en_entry_i;
    end
  end

  always_comb begin
    paddr_d = paddr_q;
    miss_d  = miss_q;
    if (state_q == LOOKUP) begin
      paddr_d = hit ? {rd_ppn, vaddr_q[PAGE_BITS-1:0]} : '0;
      miss_d  = ~hit;
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q <= IDLE;
      vld_q   <= '0;
      vaddr_q <= '0;
      paddr_q <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      paddr_q <= paddr_d;
      miss_q  <= miss_d;
      if (req_hs) begin
        vaddr_q <= req_addr_vaddr_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_hs) state_d = LOOKUP;
      LOOKUP:  state_d = RESP;
      RESP:    if (resp_addr_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Table writes take priority; a request stalls one cycle behind them
  always_comb begin
    req_rdy = 1'b0;
    cfg_rdy = 1'b0;
    rsp_vld = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_rdy = 1'b1;
        req_rdy = ~cfg_wr_valid_i;
      end
      RESP:    rsp_vld = 1'b1;
      default: ;
    endcase
  end

  assign req_addr_ready_o  = req_rdy;
  assign cfg_wr_ready_o    = cfg_rdy;
  assign resp_addr_valid_o = rsp_vld;
  assign resp_addr_paddr_o = paddr_q;
  assign resp_addr_miss_o  = miss_q;

`ifdef ROCE_ADDR_XLAT_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (resp_hs) begin
      if (miss_q) begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
      end else begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign stat_hit_cnt_o  = hit_cnt_q;
  assign stat_miss_cnt_o = miss_cnt_q;
`else
  assign stat_hit_cnt_o  = '0;
  assign stat_miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_roce_stack_addr_translator.sv
// Bench for roce_stack_addr_translator: vector table, corner sequences,
// and random traffic checked against a whole-VPN page-table model.
module tb_roce_stack_addr_translator;

  localparam int NE = 64;
  localparam int PB = 21;
  localparam int VW = 64 - PB;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          req_valid;
  logic          req_ready;
  logic [63:0]   req_vaddr;
  logic          resp_valid;
  logic          resp_ready;
  logic [63:0]   paddr;
  logic          miss;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [VW-1:0] cfg_vpn;
  logic [VW-1:0] cfg_ppn;
  logic          cfg_en;
  logic          flush;
  logic [31:0]   stat_hit;
  logic [31:0]   stat_miss;

  always #5 clk = ~clk;

  roce_stack_addr_translator #(
    .NUM_ENTRIES(NE),
    .PAGE_BITS  (PB)
  ) dut (
    .clk_i            (clk),
    .aresetn_i        (aresetn),
    .req_addr_valid_i (req_valid),
    .req_addr_ready_o (req_ready),
    .req_addr_vaddr_i (req_vaddr),
    .resp_addr_valid_o(resp_valid),
    .resp_addr_ready_i(resp_ready),
    .resp_addr_paddr_o(paddr),
    .resp_addr_miss_o (miss),
    .cfg_wr_valid_i   (cfg_valid),
    .cfg_wr_ready_o   (cfg_ready),
    .cfg_wr_vpn_i     (cfg_vpn),
    .cfg_wr_ppn_i     (cfg_ppn),
    .cfg_wr_en_entry_i(cfg_en),
    .flush_i          (flush),
    .stat_hit_cnt_o   (stat_hit),
    .stat_miss_cnt_o  (stat_miss)
  );

  int checks = 0;
  int errors = 0;

  // Reference page table: holds the full VPN, so aliasing is judged by equality
  bit            mv   [NE];
  logic [VW-1:0] mvpn [NE];
  logic [VW-1:0] mppn [NE];
  int            mhit = 0;
  int            mmiss = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat(input int c);
`ifdef ROCE_ADDR_XLAT_STATS_EN
    return 32'(c);
`else
    return 32'd0 + 32'(c & 0);
`endif
  endfunction

  task automatic model_flush();
    for (int i = 0; i < NE; i++) mv[i] = 1'b0;
  endtask

  task automatic model_reset();
    model_flush();
    mhit  = 0;
    mmiss = 0;
  endtask

  task automatic model_write(input logic [VW-1:0] vpn, input logic [VW-1:0] ppn, input bit en);
    int i;
    i = int'(vpn % NE);
    mv[i]   = en;
    mvpn[i] = vpn;
    mppn[i] = ppn;
  endtask

  task automatic model_lookup(input logic [63:0] va, output logic [63:0] ep, output bit em);
    logic [VW-1:0] vpn;
    int i;
    vpn = VW'(va >> PB);
    i   = int'(vpn % NE);
    if (mv[i] && mvpn[i] == vpn) begin
      ep = (64'(mppn[i]) << PB) + (va % (64'd1 << PB));
      em = 1'b0;
    end else begin
      ep = '0;
      em = 1'b1;
    end
  endtask

  task automatic cfg_write(input logic [63:0] vpn, input logic [63:0] ppn,
                           input bit en, input bit fl);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_vpn   = vpn[VW-1:0];
    cfg_ppn   = ppn[VW-1:0];
    cfg_en    = en;
    flush     = fl;
    #1 check("cfg_ready", cfg_ready, 1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    flush     = 1'b0;
    if (fl) model_flush();
    model_write(vpn[VW-1:0], ppn[VW-1:0], en);
  endtask

  task automatic lookup(input logic [63:0] va, input int hold, input bit fa, input bit fl,
                        output logic [63:0] pa, output logic ms);
    int n;
    logic [63:0] ep;
    bit em;
    pa = '0;
    ms = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_vaddr = va;
    flush     = fa;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      check("req_ready_timeout", req_ready, 1);
      req_valid = 1'b0;
      flush     = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    if (fa) model_flush();
    @(negedge clk);
    check("lat_lookup_valid", resp_valid, 0);
    check("lookup_readies", {req_ready, cfg_ready}, 0);
    flush = fl;
    @(posedge clk);
    #1 flush = 1'b0;
    if (fl) model_flush();
    model_lookup(va, ep, em);
    @(negedge clk);
    check("lat_resp_valid", resp_valid, 1);
    n = 0;
    while (resp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (resp_valid !== 1'b1) begin
      check("resp_timeout", resp_valid, 1);
      return;
    end
    pa = paddr;
    ms = miss;
    check("model_paddr", pa, ep);
    check("model_miss", ms, em);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", resp_valid, 1);
      check("hold_paddr", paddr, pa);
      check("hold_miss", miss, ms);
      check("hold_readies", {req_ready, cfg_ready}, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    if (em) mmiss++;
    else    mhit++;
    @(negedge clk);
    check("idle_after_resp", resp_valid, 0);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_hit_cnt"}, stat_hit, exp_stat(mhit));
    check({tag, "_miss_cnt"}, stat_miss, exp_stat(mmiss));
  endtask

  typedef struct {
    bit          cfg;
    logic [63:0] a;
    logic [63:0] b;
    bit          en;
    logic [63:0] ep;
    bit          em;
  } vec_t;

  vec_t tv[$];

  initial begin
    logic [63:0] pa;
    logic        ms;
    logic [63:0] va;
    logic [63:0] vpn;

    tv.push_back('{1'b0, 64'h0000_0000_0023_4567, 64'h0, 1'b0, 64'h0, 1'b1});
    tv.push_back('{1'b1, 64'h1, 64'h80, 1'b1, 64'h0, 1'b0});
    tv.push_back('{1'b0, 64'h0000_0000_0023_4567, 64'h0, 1'b0, 64'h0000_0000_1003_4567, 1'b0});
    tv.push_back('{1'b1, 64'h41, 64'h90, 1'b1, 64'h0, 1'b0});
    tv.push_back('{1'b0, 64'h0000_0000_0020_0000, 64'h0, 1'b0, 64'h0, 1'b1});
    tv.push_back('{1'b0, 64'h0000_0000_0820_0000, 64'h0, 1'b0, 64'h0000_0000_1200_0000, 1'b0});
    tv.push_back('{1'b1, 64'h41, 64'h90, 1'b0, 64'h0, 1'b0});
    tv.push_back('{1'b0, 64'h0000_0000_0820_0000, 64'h0, 1'b0, 64'h0, 1'b1});
    tv.push_back('{1'b1, 64'h3F, 64'h5, 1'b1, 64'h0, 1'b0});
    tv.push_back('{1'b0, 64'h0000_0000_07FF_FFFF, 64'h0, 1'b0, 64'h0000_0000_00BF_FFFF, 1'b0});
    tv.push_back('{1'b1, 64'h7FF_FFFF_FFFF, 64'h7FF_FFFF_FFFF, 1'b1, 64'h0, 1'b0});
    tv.push_back('{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    tv.push_back('{1'b0, 64'h0000_0000_07FF_FFFF, 64'h0, 1'b0, 64'h0, 1'b1});
    tv.push_back('{1'b0, 64'h0, 64'h0, 1'b0, 64'h0, 1'b1});

    aresetn    = 1'b0;
    req_valid  = 1'b0;
    req_vaddr  = '0;
    resp_ready = 1'b0;
    cfg_valid  = 1'b0;
    cfg_vpn    = '0;
    cfg_ppn    = '0;
    cfg_en     = 1'b0;
    flush      = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_paddr", paddr, 0);
    check("rst_miss", miss, 0);
    check_stats("rst");
    aresetn = 1'b1;

    foreach (tv[i]) begin
      if (tv[i].cfg) begin
        cfg_write(tv[i].a, tv[i].b, tv[i].en, 1'b0);
      end else begin
        lookup(tv[i].a, i % 3, 1'b0, 1'b0, pa, ms);
        check($sformatf("vec%0d_paddr", i), pa, tv[i].ep);
        check($sformatf("vec%0d_miss", i), ms, tv[i].em);
      end
    end
    check_stats("vec");

    // Write and request in the same idle cycle
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_vpn   = VW'(64'h123);
    cfg_ppn   = VW'(64'h456);
    cfg_en    = 1'b1;
    req_valid = 1'b1;
    req_vaddr = (64'h123 << PB) | 64'h1ABC;
    #1;
    check("wr_wins_req_ready", req_ready, 0);
    check("wr_wins_cfg_ready", cfg_ready, 1);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    model_write(VW'(64'h123), VW'(64'h456), 1'b1);
    @(negedge clk);
    check("req_ready_after_wr", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("same_cyc_lookup_valid", resp_valid, 0);
    @(negedge clk);
    check("same_cyc_resp_valid", resp_valid, 1);
    check("same_cyc_paddr", paddr, (64'h456 << PB) | 64'h1ABC);
    check("same_cyc_miss", miss, 0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    mhit++;

    // Long backpressure on the response
    lookup(64'hFFFF_FFFF_FFFF_FFFF, 10, 1'b0, 1'b0, pa, ms);
    check("stall_paddr", pa, 64'hFFFF_FFFF_FFFF_FFFF);

    // Flush in the accept cycle, then in the lookup cycle
    lookup((64'h123 << PB) | 64'h10, 0, 1'b1, 1'b0, pa, ms);
    check("flush_acc_miss", ms, 1);
    check("flush_acc_paddr", pa, 0);
    cfg_write(64'h123, 64'h456, 1'b1, 1'b0);
    lookup((64'h123 << PB) | 64'h20, 1, 1'b0, 1'b1, pa, ms);
    check("flush_lk_miss", ms, 1);

    // Flush coinciding with a write keeps the written entry
    cfg_write(64'h5, 64'h77, 1'b1, 1'b0);
    cfg_write(64'h22, 64'h33, 1'b1, 1'b1);
    lookup((64'h22 << PB) | 64'h5, 0, 1'b0, 1'b0, pa, ms);
    check("flush_wr_hit", ms, 0);
    check("flush_wr_paddr", pa, (64'h33 << PB) | 64'h5);
    lookup(64'h5 << PB, 0, 1'b0, 1'b0, pa, ms);
    check("flush_wr_other_miss", ms, 1);
    check_stats("corner");

    for (int it = 0; it < 200; it++) begin
      vpn = (64'($urandom_range(0, 3)) << 30) | 64'($urandom_range(0, 150));
      if ($urandom_range(0, 9) < 4) begin
        cfg_write(vpn, {$urandom, $urandom}, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 31) == 0);
      end else begin
        va = (vpn << PB) | (64'($urandom) % (64'd1 << PB));
        lookup(va, $urandom_range(0, 3), $urandom_range(0, 31) == 0,
               $urandom_range(0, 31) == 0, pa, ms);
      end
    end
    check_stats("rand");

    // Asynchronous reset while holding a response
    cfg_write(64'h10, 64'h20, 1'b1, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_vaddr = 64'h10 << PB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_resp_valid", resp_valid, 1);
    #2 aresetn = 1'b0;
    #1;
    check("rst_in_resp_valid", resp_valid, 0);
    check("rst_in_resp_req_ready", req_ready, 1);
    check("rst_in_resp_paddr", paddr, 0);
    model_reset();
    @(negedge clk);
    aresetn = 1'b1;
    check_stats("post_rst");
    lookup(64'h10 << PB, 0, 1'b0, 1'b0, pa, ms);
    check("post_rst_miss", ms, 1);
    check_stats("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
